// File: rtl/pkt_gen_pkg.sv
// pkt_gen_pkg: FSM state type and beat/empty arithmetic shared by the packet source.
package pkt_gen_pkg;

    typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

    function automatic logic [31:0] beats_of(input logic [31:0] len, input logic [31:0] bpb);
        return (len + bpb - 32'd1) / bpb;
    endfunction

    function automatic logic [31:0] empty_of(input logic [31:0] len, input logic [31:0] bpb);
        return beats_of(len, bpb) * bpb - len;
    endfunction

endpackage

// File: rtl/pkt_gen.sv
// pkt_gen: Avalon-ST packet source with programmed length, count and inter-packet gap.
module pkt_gen
    import pkt_gen_pkg::*;
#(
    parameter int DATA_W  = 512,
    parameter int EMPTY_W = 6,
    parameter int LEN_W   = 16,
    parameter int GAP_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [31:0]        num_pkts,
    input  logic [LEN_W-1:0]   pkt_len,
    input  logic [GAP_W-1:0]   gap,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sop,
    output logic               out_eop,
    output logic [EMPTY_W-1:0] out_empty,
    output logic               busy,
    output logic               done,
    output logic [31:0]        pkt_cnt
);

    localparam logic [31:0] BPB = 32'(DATA_W / 8);

    state_t           state, state_n;
    logic [31:0]      n_pkts_r, len_r, len_eff, len_n, beats_n, empty_n, pkt_cnt_n;
    logic [GAP_W-1:0] gap_r, gap_cnt, gap_cnt_n;
    logic [15:0]      pkt_idx, pkt_idx_n, beat_idx, beat_idx_n;
    logic             load, hs, sop_n, eop_n;

    assign out_valid = state == SEND;
    assign busy      = state != IDLE;
    assign done      = state == FIN;
    assign hs        = out_valid & out_ready;
    assign load      = state == IDLE && start;
    assign len_eff   = pkt_len == '0 ? 32'd1 : 32'(pkt_len);
    assign len_n     = load ? len_eff : len_r;
    assign beats_n   = beats_of(len_n, BPB);
    assign empty_n   = empty_of(len_n, BPB);

    always_comb begin
        state_n    = state;
        pkt_idx_n  = pkt_idx;
        beat_idx_n = beat_idx;
        pkt_cnt_n  = pkt_cnt;
        gap_cnt_n  = gap_cnt;
        case (state)
            IDLE: if (start) begin
                pkt_cnt_n  = '0;
                pkt_idx_n  = '0;
                beat_idx_n = '0;
                state_n    = num_pkts == '0 ? FIN : SEND;
            end
            SEND: if (hs) begin
                // out_eop is the registered "current beat is last" flag
                beat_idx_n = out_eop ? 16'd0 : beat_idx + 16'd1;
                if (out_eop) begin
                    pkt_cnt_n = pkt_cnt + 32'd1;
                    pkt_idx_n = pkt_idx + 16'd1;
                    gap_cnt_n = gap_r;
                    state_n   = pkt_cnt_n == n_pkts_r ? FIN : gap_r == '0 ? SEND : GAP;
                end
            end
            GAP: begin
                gap_cnt_n = gap_cnt - GAP_W'(1);
                state_n   = gap_cnt == GAP_W'(1) ? SEND : GAP;
            end
            default: state_n = IDLE;
        endcase
    end

    assign sop_n = state_n == SEND && beat_idx_n == 16'd0;
    assign eop_n = state_n == SEND && {16'd0, beat_idx_n} == beats_n - 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            n_pkts_r  <= '0;
            len_r     <= 32'd1;
            gap_r     <= '0;
            gap_cnt   <= '0;
            pkt_idx   <= '0;
            beat_idx  <= '0;
            pkt_cnt   <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_empty <= '0;
            out_data  <= '0;
        end else begin
            state     <= state_n;
            gap_cnt   <= gap_cnt_n;
            pkt_idx   <= pkt_idx_n;
            beat_idx  <= beat_idx_n;
            pkt_cnt   <= pkt_cnt_n;
            out_sop   <= sop_n;
            out_eop   <= eop_n;
            out_empty <= eop_n ? empty_n[EMPTY_W-1:0] : '0;
            out_data  <= state_n == SEND ? {(DATA_W/32){pkt_idx_n, beat_idx_n}} : '0;
            if (load) begin
                n_pkts_r <= num_pkts;
                len_r    <= len_eff;
                gap_r    <= gap;
            end
        end
    end

endmodule

// File: tb/tb_pkt_gen.sv
// tb_pkt_gen: randomized scoreboard bench; expected beats come from a packet-level model.
module tb_pkt_gen;

    localparam int DATA_W = 512;
    localparam int BPB    = DATA_W / 8;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              s;
        logic              e;
        logic [5:0]        em;
    } beat_t;

    logic              clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b1;
    logic [31:0]       num_pkts = '0;
    logic [15:0]       pkt_len = '0;
    logic [7:0]        gap = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid, out_sop, out_eop, busy, done;
    logic [5:0]        out_empty;
    logic [31:0]       pkt_cnt;

    int    vectors = 0, miscompares = 0;
    beat_t q[$];
    bit    ready_rnd = 0, ignore = 1, after_eop = 0;
    int    cur_gap = 0, idle = 0;

    pkt_gen dut (
        .clk(clk), .rst(rst), .start(start), .num_pkts(num_pkts), .pkt_len(pkt_len),
        .gap(gap), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty), .busy(busy),
        .done(done), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1 out_ready = ready_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: scoreboard pop on handshake, hold-under-stall and gap length checks
    initial begin
        logic              stall = 0;
        logic [DATA_W-1:0] sd;
        logic              ss, se;
        logic [5:0]        sem;
        beat_t             b;
        forever begin
            @(negedge clk);
            if (ignore || rst) begin
                stall = 0;
            end else begin
                if (stall) begin
                    chk("hold_valid", DATA_W'(out_valid), DATA_W'(1));
                    chk("hold_data", out_data, sd);
                    chk("hold_frame", DATA_W'({out_sop, out_eop, out_empty}), DATA_W'({ss, se, sem}));
                end
                if (out_valid && after_eop) begin
                    chk("gap_len", DATA_W'(idle), DATA_W'(cur_gap));
                    after_eop = 0;
                end else if (!out_valid && after_eop) idle++;
                if (out_valid && out_ready) begin
                    if (q.size() == 0) chk("unexpected_beat", DATA_W'(1), DATA_W'(0));
                    else begin
                        b = q.pop_front();
                        chk("data", out_data, b.d);
                        chk("sop_eop_empty", DATA_W'({out_sop, out_eop, out_empty}), DATA_W'({b.s, b.e, b.em}));
                    end
                    if (out_eop) begin
                        after_eop = 1;
                        idle = 0;
                    end
                end
                stall = out_valid && !out_ready;
                sd = out_data; ss = out_sop; se = out_eop; sem = out_empty;
            end
        end
    end

    task automatic push_model(input int n, input int len);
        int    l, nb;
        beat_t b;
        logic [31:0] w;
        l  = len == 0 ? 1 : len;
        nb = (l + BPB - 1) / BPB;
        for (int p = 0; p < n; p++)
            for (int k = 0; k < nb; k++) begin
                w    = {16'(p), 16'(k)};
                b.d  = {(DATA_W/32){w}};
                b.s  = k == 0;
                b.e  = k == nb - 1;
                b.em = b.e ? 6'(nb * BPB - l) : 6'd0;
                q.push_back(b);
            end
    endtask

    task automatic run(input int n, input int len, input int g, input bit rnd, input bit stray);
        int t = 0;
        ready_rnd = rnd;
        cur_gap   = g;
        after_eop = 0;
        push_model(n, len);
        @(negedge clk);
        num_pkts = n; pkt_len = 16'(len); gap = 8'(g); start = 1;
        @(negedge clk);
        start = 0;
        num_pkts = $urandom; pkt_len = 16'($urandom); gap = 8'($urandom);
        if (n == 0) chk("zero_done_next", DATA_W'(done), DATA_W'(1));
        if (stray) begin
            @(negedge clk);
            start = 1;
            @(negedge clk);
            start = 0;
        end
        while (!done && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", DATA_W'(done), DATA_W'(1));
        chk("busy_at_done", DATA_W'(busy), DATA_W'(1));
        chk("pkt_cnt", DATA_W'(pkt_cnt), DATA_W'(n));
        chk("queue_drained", DATA_W'(q.size()), DATA_W'(0));
        q.delete();
        @(negedge clk);
        chk("done_pulse", DATA_W'({done, busy}), DATA_W'(0));
        chk("pkt_cnt_hold", DATA_W'(pkt_cnt), DATA_W'(n));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outs", DATA_W'({out_valid, out_sop, out_eop, out_empty, busy, done}), DATA_W'(0));
        chk("reset_data", out_data, '0);
        chk("reset_cnt", DATA_W'(pkt_cnt), DATA_W'(0));
        rst = 0;
        ignore = 0;
        run(3, 64, 0, 0, 0);
        run(1, 130, 0, 0, 0);
        run(4, 200, 0, 1, 1);
        run(2, 64, 5, 0, 0);
        run(0, 64, 3, 0, 0);
        run(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            run($urandom_range(1, 4), $urandom_range(0, 300), $urandom_range(0, 3), 1, 0);
        // Reset in the middle of a 3-beat packet, then a clean rerun
        ignore = 1;
        ready_rnd = 0;
        @(negedge clk);
        num_pkts = 1; pkt_len = 16'd130; gap = 0; start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        chk("mid_beat1", DATA_W'({out_valid, out_sop, out_data[15:0]}), DATA_W'({1'b1, 1'b0, 16'd1}));
        rst = 1;
        @(negedge clk);
        chk("rst_mid", DATA_W'({out_valid, busy, done, out_sop, out_eop}), DATA_W'(0));
        rst = 0;
        ignore = 0;
        run(1, 130, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
